// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage
// Purpose : Memory stage of the five-stage ARM pipeline. Holds the EX/MEM
//           pipeline register and performs the data access, either against an
//           internal word-addressed data RAM or against a memory-mapped I/O
//           window served by a req/ack handshake. It then drives the MEM/WB
//           pipeline register consumed by writeback. An I/O access stalls the
//           pipeline through StallM until the handshake completes.
// Ports   : Clk, reset (async, active-low)
//           ALUResultE/WriteDataE/WA3E + RegWrite/MemToReg/MemWrite/PCSrc E-ctrl
//           ALUResultM/WA3M/RegWriteM : EX/MEM contents used for forwarding
//           StallM                    : freezes upstream stages and EX/MEM
//           ReadDataW/ALUOutW/WA3W/RegWriteW/MemToRegW/PCSrcW : MEM/WB contents
//           io_req/io_we/io_addr/io_wdata/io_rdata/io_ack : I/O handshake
//           io_err                    : sticky I/O timeout flag
// Config  : MEM_STAGE_TIMEOUT_EN - when defined, an I/O wait longer than
//           TIMEOUT_CYCLES forces completion (loads return 32'hDEAD_BEEF,
//           stores are dropped) and sets io_err. When undefined, io_err is 0
//           and the stage waits for io_ack indefinitely.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage #(
  parameter int          RAM_WORDS      = 64,
  parameter logic [31:0] IO_BASE        = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic [31:0] ALUResultE,
  input  logic [31:0] WriteDataE,
  input  logic [3:0]  WA3E,
  input  logic        RegWriteE,
  input  logic        MemToRegE,
  input  logic        MemWriteE,
  input  logic        PCSrcE,
  output logic [31:0] ALUResultM,
  output logic [3:0]  WA3M,
  output logic        RegWriteM,
  output logic        StallM,
  output logic [31:0] ReadDataW,
  output logic [31:0] ALUOutW,
  output logic [3:0]  WA3W,
  output logic        RegWriteW,
  output logic        MemToRegW,
  output logic        PCSrcW,
  output logic        io_req,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        io_err
);

  localparam int ADDR_W = $clog2(RAM_WORDS);

  // Elaboration-time parameter sanity checks.
  if (RAM_WORDS < 2 || (RAM_WORDS & (RAM_WORDS - 1)) != 0) begin : g_bad_ram_words
    $error("mem_stage: RAM_WORDS must be a power of two of at least 2");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_stage: TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  // EX/MEM fields that are not ports
  logic [31:0] write_data_m;
  logic        mem_to_reg_m;
  logic        mem_write_m;
  logic        pcsrc_m;

  logic [31:0]       ram [RAM_WORDS];
  logic [ADDR_W-1:0] ram_idx;
  logic              in_io_window;
  logic              io_access;
  logic              ram_write;
  logic              timeout_hit;
  logic [31:0]       load_data;

  // --------------------------------------------------------------------------
  // Access decode
  // --------------------------------------------------------------------------
  assign in_io_window = (ALUResultM[31:16] == IO_BASE[31:16]);
  assign io_access    = (mem_write_m | mem_to_reg_m) & in_io_window;
  assign ram_write    = mem_write_m & ~in_io_window;
  // Upper address bits are dropped, so RAM addresses wrap.
  assign ram_idx      = ALUResultM[ADDR_W+1:2];

  // While in REQ the only way MEM/WB can load is completion of the handshake,
  // so the load data then comes from the I/O side (or the timeout pattern).
  assign load_data = (state == REQ) ? (timeout_hit ? 32'hDEAD_BEEF : io_rdata)
                                    : ram[ram_idx];

  // --------------------------------------------------------------------------
  // EX/MEM pipeline register
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ALUResultM   <= '0;
      write_data_m <= '0;
      WA3M         <= '0;
      RegWriteM    <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_write_m  <= 1'b0;
      pcsrc_m      <= 1'b0;
    end else if (!StallM) begin
      ALUResultM   <= ALUResultE;
      write_data_m <= WriteDataE;
      WA3M         <= WA3E;
      RegWriteM    <= RegWriteE;
      mem_to_reg_m <= MemToRegE;
      mem_write_m  <= MemWriteE;
      pcsrc_m      <= PCSrcE;
    end
  end

  // --------------------------------------------------------------------------
  // Data RAM write port (contents are intentionally not reset)
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (ram_write) begin
      ram[ram_idx] <= write_data_m;
    end
  end

  // --------------------------------------------------------------------------
  // MEM/WB pipeline register. A stall inserts a bubble by clearing the
  // controls; the data fields simply hold.
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      ReadDataW <= '0;
      ALUOutW   <= '0;
      WA3W      <= '0;
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
      MemToRegW <= 1'b0;
      PCSrcW    <= 1'b0;
    end else begin
      ReadDataW <= load_data;
      ALUOutW   <= ALUResultM;
      WA3W      <= WA3M;
      RegWriteW <= RegWriteM;
      MemToRegW <= mem_to_reg_m;
      PCSrcW    <= pcsrc_m;
    end
  end

  // --------------------------------------------------------------------------
  // I/O handshake FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    io_req     = 1'b0;
    io_we      = 1'b0;
    io_addr    = '0;
    io_wdata   = '0;
    case (state)
      IDLE: begin
        // The IDLE cycle guarantees io_req drops between transactions.
        if (io_access) begin
          StallM     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        io_req   = 1'b1;
        io_we    = mem_write_m;
        io_addr  = ALUResultM;
        io_wdata = write_data_m;
        if (io_ack || timeout_hit) begin
          state_next = IDLE;
        end else begin
          StallM = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Optional I/O wait timeout
  // --------------------------------------------------------------------------
`ifdef MEM_STAGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;

  assign timeout_hit = (state == REQ) && !io_ack && (wait_cnt == TIMEOUT_LIMIT);

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      io_err   <= 1'b0;
    end else begin
      // Holding the counter at zero in IDLE clears it on entry to REQ.
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (!io_ack && !timeout_hit) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
      if (timeout_hit) begin
        io_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign io_err      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage
// Purpose : Self-checking bench for mem_stage. An upstream driver issues
//           instructions and holds them while StallM is high; each accepted
//           instruction is queued with its expected writeback and compared
//           when it reaches MEM/WB. Table vectors cover RAM traffic; short
//           hand-written sequences cover I/O, back-to-back I/O, timeout and
//           reset in the middle of a request.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wdata;
    logic [3:0]  wa3;
    logic        rw;
    logic        mtr;
    logic        mw;
    logic        pcs;
    logic [31:0] exp_rd;
    logic        chk_rd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ALUResultE = '0;
  logic [31:0] WriteDataE = '0;
  logic [3:0]  WA3E = '0;
  logic        RegWriteE = 1'b0;
  logic        MemToRegE = 1'b0;
  logic        MemWriteE = 1'b0;
  logic        PCSrcE = 1'b0;
  logic [31:0] io_rdata = '0;
  logic        io_ack = 1'b0;

  logic [31:0] ALUResultM, ReadDataW, ALUOutW, io_addr, io_wdata;
  logic [3:0]  WA3M, WA3W;
  logic        RegWriteM, StallM, RegWriteW, MemToRegW, PCSrcW;
  logic        io_req, io_we, io_err;

  mem_stage #(
    .RAM_WORDS     (64),
    .IO_BASE       (32'h0001_0000),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .Clk       (clk),
    .reset     (rst_n),
    .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE),
    .WA3E      (WA3E),
    .RegWriteE (RegWriteE),
    .MemToRegE (MemToRegE),
    .MemWriteE (MemWriteE),
    .PCSrcE    (PCSrcE),
    .ALUResultM(ALUResultM),
    .WA3M      (WA3M),
    .RegWriteM (RegWriteM),
    .StallM    (StallM),
    .ReadDataW (ReadDataW),
    .ALUOutW   (ALUOutW),
    .WA3W      (WA3W),
    .RegWriteW (RegWriteW),
    .MemToRegW (MemToRegW),
    .PCSrcW    (PCSrcW),
    .io_req    (io_req),
    .io_we     (io_we),
    .io_addr   (io_addr),
    .io_wdata  (io_wdata),
    .io_rdata  (io_rdata),
    .io_ack    (io_ack),
    .io_err    (io_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t sb[$];
  vec_t e;
  logic mon_en = 1'b0;
  logic wb_due = 1'b0;
  logic prev_stall = 1'b0;
  int   stall_cnt = 0;
  logic log_en = 1'b0;
  logic req_log[$];
  logic [31:0] wd_log[$];
  logic we_log[$];

  // I/O responder
  logic        ack_en = 1'b1;
  int          ack_delay = 0;
  int          req_age = 0;
  logic [31:0] rdata_v = '0;
  logic [31:0] seen_addr = '0;
  logic        seen_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd,
                              input logic [3:0] wa3, input logic rw, input logic mtr,
                              input logic mw, input logic pcs,
                              input logic [31:0] rd, input logic chkrd);
    vec_t v;
    v.alu = alu; v.wdata = wd; v.wa3 = wa3; v.rw = rw; v.mtr = mtr;
    v.mw = mw; v.pcs = pcs; v.exp_rd = rd; v.chk_rd = chkrd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    ALUResultE = v.alu; WriteDataE = v.wdata; WA3E = v.wa3;
    RegWriteE = v.rw; MemToRegE = v.mtr; MemWriteE = v.mw; PCSrcE = v.pcs;
  endtask

  // Called at a falling edge; holds v on the inputs until an edge with
  // StallM low captures it, then queues its expected writeback.
  task automatic issue(input vec_t v);
    logic st;
    drive(v);
    for (int g = 0; g < 40; g++) begin
      #1;
      st = StallM;
      @(negedge clk);
      if (!st) begin
        sb.push_back(v);
        return;
      end
    end
    chk("accept_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ALUResultM"}, ALUResultM, 0);
    chk({tag, "_WA3M"}, {28'd0, WA3M}, 0);
    chk({tag, "_RegWriteM"}, {31'd0, RegWriteM}, 0);
    chk({tag, "_StallM"}, {31'd0, StallM}, 0);
    chk({tag, "_ReadDataW"}, ReadDataW, 0);
    chk({tag, "_ALUOutW"}, ALUOutW, 0);
    chk({tag, "_WA3W"}, {28'd0, WA3W}, 0);
    chk({tag, "_ctrlW"}, {29'd0, RegWriteW, MemToRegW, PCSrcW}, 0);
    chk({tag, "_io_ctrl"}, {29'd0, io_req, io_we, io_err}, 0);
    chk({tag, "_io_addr"}, io_addr, 0);
    chk({tag, "_io_wdata"}, io_wdata, 0);
  endtask

  always @(negedge clk) begin
    if (io_req) begin
      req_age++;
      if (req_age == 1) begin
        seen_addr = io_addr;
        seen_we   = io_we;
      end
      io_ack   = ack_en && (req_age > ack_delay);
      io_rdata = rdata_v;
    end else begin
      req_age = 0;
      io_ack  = 1'b0;
    end
  end

  // Writeback monitor: the head of sb reaches MEM/WB on the first edge that
  // sees StallM low after it was accepted.
  always @(negedge clk) begin
    #2;
    if (mon_en) begin
      if (wb_due) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("wb_alu", ALUOutW, e.alu);
          chk("wb_wa3", {28'd0, WA3W}, {28'd0, e.wa3});
          chk("wb_regwrite", {31'd0, RegWriteW}, {31'd0, e.rw});
          chk("wb_memtoreg", {31'd0, MemToRegW}, {31'd0, e.mtr});
          chk("wb_pcsrc", {31'd0, PCSrcW}, {31'd0, e.pcs});
          if (e.chk_rd) chk("wb_readdata", ReadDataW, e.exp_rd);
        end
      end
      if (prev_stall) chk("bubble_regwrite", {31'd0, RegWriteW}, 0);
      wb_due     = (sb.size() > 0) && !StallM;
      prev_stall = StallM;
      if (StallM) stall_cnt++;
      if (log_en) begin
        req_log.push_back(io_req);
        if (io_req) begin
          wd_log.push_back(io_wdata);
          we_log.push_back(io_we);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[12];
    vec_t nopv;
    int   first;
    nopv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[0]  = mk(32'h0000_0008, 32'h1234_5678, 4'd0, 0, 0, 1, 0, 32'h0, 0);
    tbl[1]  = mk(32'h0000_0008, 32'h0, 4'd3, 1, 1, 0, 0, 32'h1234_5678, 1);
    tbl[2]  = mk(32'h0000_0100, 32'hA5A5_A5A5, 4'd0, 0, 0, 1, 0, 32'h0, 0);
    tbl[3]  = mk(32'h0000_0000, 32'h0, 4'd5, 1, 1, 0, 0, 32'hA5A5_A5A5, 1);
    tbl[4]  = mk(32'hDEAD_0001, 32'h77, 4'd7, 1, 0, 0, 0, 32'h0, 0);
    tbl[5]  = mk(32'h0000_0040, 32'h0, 4'd15, 1, 0, 0, 1, 32'h0, 0);
    tbl[6]  = mk(32'h0000_00FF, 32'h0BAD_F00D, 4'd0, 0, 0, 1, 0, 32'h0, 0);
    tbl[7]  = mk(32'h0000_01FC, 32'h0, 4'd6, 1, 1, 0, 0, 32'h0BAD_F00D, 1);
    tbl[8]  = mk(32'h0000_0004, 32'h1111_1111, 4'd0, 0, 0, 1, 0, 32'h0, 0);
    tbl[9]  = mk(32'h0000_0005, 32'h2222_2222, 4'd0, 0, 0, 1, 0, 32'h0, 0);
    tbl[10] = mk(32'h0000_0006, 32'h0, 4'd1, 1, 1, 0, 0, 32'h2222_2222, 1);
    tbl[11] = mk(32'h0001_0030, 32'h0, 4'd2, 1, 0, 0, 0, 32'h0, 0);

    drive(nopv);
    @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // RAM traffic: never stalls
    stall_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      issue(tbl[i]);
      chk("ex_alu", ALUResultM, tbl[i].alu);
      chk("ex_wa3", {28'd0, WA3M}, {28'd0, tbl[i].wa3});
      chk("ex_regwrite", {31'd0, RegWriteM}, {31'd0, tbl[i].rw});
    end
    issue(nopv);
    issue(nopv);
    chk("ram_stall_cycles", stall_cnt, 0);

    // I/O load, ack three cycles after io_req rises
    ack_en = 1'b1; ack_delay = 3; rdata_v = 32'hCAFE_F00D;
    stall_cnt = 0;
    issue(mk(32'h0001_0004, 32'h0, 4'd9, 1, 1, 0, 0, 32'hCAFE_F00D, 1));
    issue(nopv);
    issue(nopv);
    issue(nopv);
    chk("io_load_stall_cycles", stall_cnt, 4);
    chk("io_load_addr", seen_addr, 32'h0001_0004);
    chk("io_load_we", {31'd0, seen_we}, 0);

    // Back-to-back I/O stores with immediate ack
    ack_delay = 0; rdata_v = 32'h0;
    stall_cnt = 0;
    req_log.delete(); wd_log.delete(); we_log.delete();
    log_en = 1'b1;
    issue(mk(32'h0001_0020, 32'h1111_0000, 4'd0, 0, 0, 1, 0, 32'h0, 0));
    issue(mk(32'h0001_0024, 32'h2222_0000, 4'd0, 0, 0, 1, 0, 32'h0, 0));
    issue(nopv);
    issue(nopv);
    issue(nopv);
    log_en = 1'b0;
    chk("b2b_stall_cycles", stall_cnt, 2);
    first = -1;
    for (int i = 0; i < req_log.size(); i++) begin
      if (first < 0 && req_log[i]) first = i;
    end
    if (first >= 0 && first + 3 < req_log.size() && wd_log.size() == 2) begin
      chk("b2b_req_pattern", {28'd0, req_log[first], req_log[first+1],
                              req_log[first+2], req_log[first+3]}, 32'b1010);
      chk("b2b_wdata0", wd_log[0], 32'h1111_0000);
      chk("b2b_wdata1", wd_log[1], 32'h2222_0000);
      chk("b2b_we", {30'd0, we_log[0], we_log[1]}, 32'b11);
    end else begin
      chk("b2b_req_log_size", req_log.size(), 32'd999);
    end

`ifdef MEM_STAGE_TIMEOUT_EN
    // I/O load that is never acknowledged
    ack_en = 1'b0;
    stall_cnt = 0;
    issue(mk(32'h0001_0008, 32'h0, 4'd2, 1, 1, 0, 0, 32'hDEAD_BEEF, 1));
    issue(nopv);
    issue(nopv);
    issue(nopv);
    chk("timeout_stall_cycles", stall_cnt, 9);
    chk("timeout_io_err", {31'd0, io_err}, 1);
    repeat (3) @(negedge clk);
    chk("timeout_io_err_sticky", {31'd0, io_err}, 1);
`else
    chk("io_err_tied_low", {31'd0, io_err}, 0);
`endif

    // Reset while in REQ
    ack_en = 1'b0;
    issue(mk(32'h0001_0010, 32'h0, 4'd4, 1, 1, 0, 0, 32'h0, 0));
    drive(nopv);
    @(negedge clk);
    chk("rst_pre_req", {31'd0, io_req}, 1);
    #3;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, io_req}, 0);
    chk("rst_async_stall", {31'd0, StallM}, 0);
    sb.delete();
    wb_due = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk_all_zero("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage ARM pipeline, directly downstream of `execute`. It registers the execute results into the EX/MEM pipeline register. It then performs the data access against an internal word-addressed data RAM, or against a memory-mapped I/O window used by the camera path through a req/ack handshake. Finally, it drives the MEM/WB pipeline register consumed by writeback. I/O accesses stall the pipeline through `StallM` until the handshake completes.

## Interface
Parameters:
- `RAM_WORDS`, default 64: data RAM depth in 32-bit words. Must be a power of two.
- `IO_BASE`, default 32'h0001_0000: I/O window base. An address is I/O when `addr[31:16] == IO_BASE[31:16]`.
- `TIMEOUT_CYCLES`, default 255: I/O wait limit. Used only with `MEM_STAGE_TIMEOUT_EN`.

Ports:
- `Clk`, in, 1: the single clock, rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `ALUResultE`, in, 32: address or ALU result from execute.
- `WriteDataE`, in, 32: store data.
- `WA3E`, in, 4: destination register.
- `RegWriteE`, `MemToRegE`, `MemWriteE`, `PCSrcE`, in, 1 each: condition-resolved controls.
- `ALUResultM`, out, 32: EX/MEM address/result, used for forwarding.
- `WA3M`, out, 4: EX/MEM destination register.
- `RegWriteM`, out, 1: EX/MEM register-write control.
- `StallM`, out, 1: freezes upstream stages and EX/MEM.
- `ReadDataW`, out, 32: MEM/WB load data.
- `ALUOutW`, out, 32: MEM/WB ALU result.
- `WA3W`, out, 4: MEM/WB destination register.
- `RegWriteW`, `MemToRegW`, `PCSrcW`, out, 1 each: MEM/WB controls.
- `io_req`, out, 1: I/O request.
- `io_we`, out, 1: I/O write strobe.
- `io_addr`, out, 32: I/O address.
- `io_wdata`, out, 32: I/O write data.
- `io_rdata`, in, 32: I/O read data.
- `io_ack`, in, 1: I/O acknowledge.
- `io_err`, out, 1: sticky I/O timeout flag.

## Operation
- **EX/MEM register:**
  - Captures all E inputs on each rising edge when `StallM=0`.
  - Holds its contents when `StallM=1`.
- **Access type:**
  - Access = `MemWriteM | MemToRegM`.
  - I/O access = access and the address is in the I/O window.
  - RAM access = access and the address is not in the I/O window.
- **RAM addressing:**
  - Index = `ALUResultM[log2(RAM_WORDS)+1:2]`.
  - Upper bits are ignored, so addresses wrap around.
  - Byte offset bits [1:0] are ignored.
- **RAM write:** performed at the rising edge when `MemWriteM=1` and the access is not I/O.
- **RAM read:**
  - RAM is read at the same edge into `ReadDataW`.
  - RAM accesses never stall.
  - RAM contents are not reset.
- **FSM states:** IDLE and REQ.
  - **IDLE:** if an I/O access is present, `StallM=1` combinationally and next state is REQ.
  - **REQ, outputs:** `io_req=1`, `io_we=MemWriteM`, `io_addr=ALUResultM`, `io_wdata=WriteDataM`. All are stable until ack.
  - **REQ, stall:** `StallM = ~io_ack`.
  - **REQ, on `io_ack=1`:**
    - MEM/WB captures `io_rdata` into `ReadDataW`.
    - EX/MEM advances.
    - Next state is IDLE.
  - `io_ack` outside REQ is ignored.
- **MEM/WB register:**
  - Captures every edge when `StallM=0`.
  - When `StallM=1`, it loads a bubble: `RegWriteW=MemToRegW=PCSrcW=0`, data fields don't-care (implemented as held).
- **Back-to-back I/O:** successive I/O accesses always pass through IDLE, so `io_req` is low for at least one cycle between transactions.
- **Reset (async, `reset=0`):**
  - All pipeline registers clear to 0.
  - FSM goes to IDLE, so `io_req` and `StallM` drop immediately.
  - `io_err` clears to 0.
  - Reset during REQ abandons the transaction. The I/O side must tolerate the dropped request.

## Timing
- RAM load/store: 1 cycle in M. `ReadDataW` is valid the cycle after the instruction sits in EX/MEM.
- I/O access: minimum 2 cycles in M (IDLE cycle, then REQ with same-cycle ack).
  - Each cycle of ack delay adds one cycle.
  - `StallM` is high for (1 + ack delay) cycles.
- Every output resets to 0.

## Configuration
- **`MEM_STAGE_TIMEOUT_EN` defined:**
  - An 8-bit counter clears on entering REQ and increments each REQ cycle without ack.
  - When the counter reaches `TIMEOUT_CYCLES`, the stage forces completion:
    - `StallM=0`.
    - A load writes back 32'hDEAD_BEEF.
    - A store is dropped.
    - `io_err` is set and held until reset.
  - The FSM returns to IDLE.
- **Undefined:**
  - No counter.
  - `io_err` is tied to 0.
  - REQ waits indefinitely for `io_ack`.

## Test plan
- **RAM store/load:**
  - Stimulus: store 32'h1234_5678 to 0x8, then load 0x8 with `WA3E=3`.
  - Required: `ReadDataW=32'h1234_5678`, `MemToRegW=1`, `RegWriteW=1`, `WA3W=3`; `StallM` never asserted.
- **RAM wrap (`RAM_WORDS=64`):**
  - Stimulus: store 32'hA5A5_A5A5 to 0x100, then load 0x0.
  - Required: `ReadDataW=32'hA5A5_A5A5`.
- **I/O load:**
  - Stimulus: load 0x0001_0004; `io_ack` arrives 3 cycles after `io_req` rises, with `io_rdata=32'hCAFE_F00D`.
  - Required: `StallM` high for 4 cycles; `RegWriteW=0` during the stall; then `ReadDataW=32'hCAFE_F00D`.
- **Back-to-back I/O stores:**
  - Stimulus: two consecutive I/O stores, ack asserted immediately.
  - Required: `io_req` pattern 1,0,1; `io_we=1`; `io_wdata` matches each store.
- **Reset during I/O:**
  - Stimulus: drive `reset=0` while in REQ.
  - Required: `io_req=0` and `StallM=0` without waiting for a clock edge; after release, all outputs are 0.
- **Timeout (macro defined, `TIMEOUT_CYCLES=8`):**
  - Stimulus: I/O load with no ack.
  - Required: after 8 REQ cycles `StallM` falls, `ReadDataW=32'hDEAD_BEEF`, and `io_err=1`, remaining set until reset.
